// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM pipeline control slice: FSM state encoding
// and default sizing for the stall controller.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_MAX_WAIT = 64;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy freeze/flush/bubble
// controls, SRAM wait watchdog and saturating performance counters.
module pipeline_stall_controller
  import arm_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             perf_clr,
  output logic             freeze_if,
  output logic             freeze_id,
  output logic             flush_if_id,
  output logic             bubble_id_exe,
  output logic             freeze_back,
  output logic             mem_timeout,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
);

  // wait counter only ever holds 1..MAX_WAIT-1
  localparam int unsigned WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  state_e          state;
  logic [WW-1:0]   wait_cnt;
  logic            mem_stall;
  logic            stall_inc;
  logic            flush_inc;
  logic            mwait_inc;

  assign mem_stall = mem_req & ~mem_ready;

  always_comb begin
    freeze_if     = 1'b0;
    freeze_id     = 1'b0;
    flush_if_id   = 1'b0;
    bubble_id_exe = 1'b0;
    freeze_back   = 1'b0;
    mem_timeout   = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_stall) begin
          freeze_if   = 1'b1;
          freeze_id   = 1'b1;
          freeze_back = 1'b1;
        end else if (branch_taken) begin
          flush_if_id   = 1'b1;
          bubble_id_exe = 1'b1;
        end else if (hazard_detected) begin
          freeze_if     = 1'b1;
          freeze_id     = 1'b1;
          bubble_id_exe = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          freeze_if   = 1'b1;
          freeze_id   = 1'b1;
          freeze_back = 1'b1;
        end
      end
      // hazard is masked here: it was computed from the flushed NOP
      ST_FLUSH: begin
        if (mem_stall) begin
          freeze_if   = 1'b1;
          freeze_id   = 1'b1;
          freeze_back = 1'b1;
        end
      end
      ST_ERROR: begin
        freeze_if   = 1'b1;
        freeze_id   = 1'b1;
        freeze_back = 1'b1;
        mem_timeout = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WW'(1);
          end else if (branch_taken) begin
            state <= ST_FLUSH;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WW'(MAX_WAIT - 1)) begin
            state <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_FLUSH: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WW'(1);
          end else begin
            state <= ST_RUN;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign state_o   = state;
  assign stall_inc = (state == ST_RUN) & ~mem_stall & ~branch_taken & hazard_detected;
  assign flush_inc = flush_if_id;
  assign mwait_inc = freeze_back & (state != ST_ERROR);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (stall_inc),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (flush_inc),
    .q   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mem_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (mwait_inc),
    .q   (mem_wait_cnt)
  );

endmodule
